// File: rtl/uart_cfg_handshake.sv
// Master/slave configuration negotiation for the UART controller, exchanging {ID,VAL} bytes via the RX/TX FIFOs.
// Define UART_CFG_TIMEOUT_EN to add the ACK/packet timeout and per-packet retry; without it waits are unbounded.
module uart_cfg_handshake #(
    parameter int                DATA_W      = 8,
    parameter int                ID_W        = 4,
    parameter int                VAL_W       = 4,
    parameter int                NUM_FIELDS  = 3,
    parameter logic [DATA_W-1:0] REQ_PKT     = 8'hA5,
    parameter logic [DATA_W-1:0] ACKN_PKT    = 8'hFF,
    parameter int                TIMEOUT_CYC = 1024,
    parameter int                MAX_RETRY   = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cfg_req_mst_i,
    input  logic [NUM_FIELDS*VAL_W-1:0] cfg_fields_i,
    input  logic [DATA_W-1:0]           rx_data_i,
    input  logic                        rx_empty_i,
    output logic                        rx_read_o,
    output logic [DATA_W-1:0]           tx_data_o,
    output logic                        tx_write_o,
    input  logic                        tx_done_i,
    output logic [NUM_FIELDS*VAL_W-1:0] cfg_o,
    output logic                        cfg_done_o,
    output logic                        cfg_error_o,
    output logic                        busy_o
);
    localparam int CFG_W = NUM_FIELDS * VAL_W;
    localparam int P_W   = $clog2(NUM_FIELDS + 2);
    localparam logic [P_W-1:0]  P_LAST = P_W'(NUM_FIELDS + 1);
    localparam logic [ID_W-1:0] ID_END = '1;

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] MST_SEND     = 3'd1;
    localparam logic [2:0] MST_WAIT_TX  = 3'd2;
    localparam logic [2:0] MST_WAIT_ACK = 3'd3;
    localparam logic [2:0] SLV_ACK      = 3'd4;
    localparam logic [2:0] SLV_WAIT_TX  = 3'd5;
    localparam logic [2:0] SLV_WAIT_PKT = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [P_W-1:0]    pkt_q, pkt_d;
    logic [CFG_W-1:0]  shadow_q, shadow_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic              end_q, end_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              rx_read, tx_write, retry_path, ack_seen, timeout, retry_ok;
    logic [DATA_W-1:0] tx_data, pkt_byte;
    logic [VAL_W-1:0]  pkt_val;
    logic [ID_W-1:0]   rx_id;
    logic [VAL_W-1:0]  rx_val;

    assign rx_id  = rx_data_i[DATA_W-1 -: ID_W];
    assign rx_val = rx_data_i[VAL_W-1:0];

`ifdef UART_CFG_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [TMR_W-1:0] timer_q;
    logic [RTY_W-1:0] retry_q;
    logic             in_wait;

    // Both wait states are only entered from a WAIT_TX state, so leaving them clears the timer.
    assign in_wait = (state_q == MST_WAIT_ACK) || (state_q == SLV_WAIT_PKT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        timer_q <= '0;
        else if (in_wait) timer_q <= timer_q + 1'b1;
        else              timer_q <= '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                retry_q <= '0;
        else if (state_q == IDLE || ack_seen)     retry_q <= '0;
        else if (retry_path && retry_ok)          retry_q <= retry_q + 1'b1;
    end

    assign timeout  = in_wait && (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    assign retry_ok = (retry_q < RTY_W'(MAX_RETRY));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYC, MAX_RETRY, ack_seen};
    assign timeout  = 1'b0;
    assign retry_ok = 1'b0;
`endif

    always_comb begin
        pkt_val = '0;
        for (int k = 0; k < NUM_FIELDS; k++)
            if (pkt_q == P_W'(k + 1)) pkt_val = shadow_q[k*VAL_W +: VAL_W];
        if (pkt_q == '0)          pkt_byte = REQ_PKT;
        else if (pkt_q == P_LAST) pkt_byte = {ID_END, {VAL_W{1'b0}}};
        else                      pkt_byte = {ID_W'(pkt_q), pkt_val};
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        pkt_d      = pkt_q;
        shadow_d   = shadow_q;
        cfg_d      = cfg_q;
        end_d      = end_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        rx_read    = 1'b0;
        tx_write   = 1'b0;
        tx_data    = '0;
        retry_path = 1'b0;
        ack_seen   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_empty_i && rx_data_i == REQ_PKT) begin
                    rx_read  = 1'b1;
                    shadow_d = cfg_q;
                    end_d    = 1'b0;
                    state_d  = SLV_ACK;
                end else if (cfg_req_mst_i) begin
                    pkt_d    = '0;
                    shadow_d = cfg_fields_i;
                    state_d  = MST_SEND;
                end
            end
            MST_SEND: begin
                tx_write = 1'b1;
                tx_data  = pkt_byte;
                state_d  = MST_WAIT_TX;
            end
            MST_WAIT_TX: if (tx_done_i) state_d = MST_WAIT_ACK;
            MST_WAIT_ACK: begin
                if (!rx_empty_i) begin
                    rx_read = 1'b1;
                    if (rx_data_i == ACKN_PKT) begin
                        ack_seen = 1'b1;
                        if (pkt_q == P_LAST) begin
                            cfg_d   = shadow_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            pkt_d   = pkt_q + 1'b1;
                            state_d = MST_SEND;
                        end
                    end else begin
                        retry_path = 1'b1;
                    end
                end else if (timeout) begin
                    retry_path = 1'b1;
                end
            end
            SLV_ACK: begin
                tx_write = 1'b1;
                tx_data  = ACKN_PKT;
                state_d  = SLV_WAIT_TX;
            end
            SLV_WAIT_TX: begin
                if (tx_done_i) begin
                    if (end_q) begin
                        cfg_d   = shadow_q;
                        done_d  = 1'b1;
                        end_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = SLV_WAIT_PKT;
                    end
                end
            end
            SLV_WAIT_PKT: begin
                if (!rx_empty_i) begin
                    rx_read = 1'b1;
                    if (rx_id != '0 && rx_id <= ID_W'(NUM_FIELDS)) begin
                        for (int k = 0; k < NUM_FIELDS; k++)
                            if (rx_id == ID_W'(k + 1)) shadow_d[k*VAL_W +: VAL_W] = rx_val;
                        state_d = SLV_ACK;
                    end else if (rx_id == ID_END) begin
                        end_d   = 1'b1;
                        state_d = SLV_ACK;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A rejected master packet is resent with the same index or the negotiation is abandoned.
        if (retry_path) begin
            if (retry_ok) begin
                state_d = MST_SEND;
            end else begin
                error_d = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            pkt_q    <= '0;
            // NOTE: the shadow is tiny and must read as zero after reset, so it is reset like any register.
            shadow_q <= '0;
            cfg_q    <= '0;
            end_q    <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
            end_q    <= end_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign rx_read_o   = rx_read;
    assign tx_write_o  = tx_write;
    assign tx_data_o   = tx_data;
    assign cfg_o       = cfg_q;
    assign cfg_done_o  = done_q;
    assign cfg_error_o = error_q;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_cfg_handshake.sv
// Self-checking bench for uart_cfg_handshake: FIFO/transmitter environment plus a packet-level model of both roles.
`timescale 1ns/1ps
module tb_uart_cfg_handshake;
    localparam int NF      = 3;
    localparam int VW      = 4;
    localparam int CW      = NF * VW;
    localparam int TO_CYC  = 16;
    localparam int RETRIES = 3;
`ifdef UART_CFG_TIMEOUT_EN
    localparam int RETRY_LIMIT = RETRIES;
`else
    localparam int RETRY_LIMIT = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_req_mst_i;
    logic [CW-1:0] cfg_fields_i;
    logic [7:0]    rx_data_i;
    logic          rx_empty_i;
    logic          rx_read_o;
    logic [7:0]    tx_data_o;
    logic          tx_write_o;
    logic          tx_done_i;
    logic [CW-1:0] cfg_o;
    logic          cfg_done_o, cfg_error_o, busy_o;

    int checks = 0, errors = 0;
    int cycle = 0, done_cnt = 0, err_cnt = 0, viol = 0;
    int lat_min = 1, lat_max = 4;
    byte unsigned rx_q[$];
    byte unsigned tx_q[$];
    int           tx_cyc_q[$];
    byte unsigned slv_pkts[$];
    logic [CW-1:0] model_cfg;

    uart_cfg_handshake #(
        .DATA_W(8), .ID_W(4), .VAL_W(VW), .NUM_FIELDS(NF),
        .REQ_PKT(8'hA5), .ACKN_PKT(8'hFF), .TIMEOUT_CYC(TO_CYC), .MAX_RETRY(RETRIES)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_req_mst_i(cfg_req_mst_i), .cfg_fields_i(cfg_fields_i),
        .rx_data_i(rx_data_i), .rx_empty_i(rx_empty_i), .rx_read_o(rx_read_o),
        .tx_data_o(tx_data_o), .tx_write_o(tx_write_o), .tx_done_i(tx_done_i),
        .cfg_o(cfg_o), .cfg_done_o(cfg_done_o), .cfg_error_o(cfg_error_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Environment: show-ahead RX FIFO, TX FIFO + transmitter (done pulse lat cycles after the push), pulse counters.
    initial begin : env
        int   done_cd;
        logic prev_wr;
        done_cd = -1; prev_wr = 1'b0;
        rx_empty_i = 1'b1; rx_data_i = 8'h00; tx_done_i = 1'b0;
        forever begin
            @(negedge clk_i);
            cycle++;
            rx_empty_i = (rx_q.size() == 0);
            rx_data_i  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
            tx_done_i  = (done_cd == 0);
            if (done_cd >= 0) done_cd--;
            #1;
            if (rst_i) begin
                prev_wr = 1'b0;
                done_cd = -1;
            end else begin
                if (rx_read_o) begin
                    if (rx_q.size() == 0) viol++;
                    else void'(rx_q.pop_front());
                end
                if (tx_write_o) begin
                    if (prev_wr) viol++;
                    tx_q.push_back(tx_data_o);
                    tx_cyc_q.push_back(cycle);
                    done_cd = $urandom_range(lat_max, lat_min) - 1;
                end
                prev_wr = tx_write_o;
                if (cfg_done_o)  done_cnt++;
                if (cfg_error_o) err_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_i); #2; end
    endtask

    task automatic wait_tx(output byte unsigned b, output int cyc);
        int n;
        n = 0; b = 8'h00; cyc = 0;
        while (tx_q.size() == 0 && n < 400) begin tick(1); n++; end
        check("tx_byte_arrives", 32'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) begin
            b   = tx_q.pop_front();
            cyc = tx_cyc_q.pop_front();
        end
    endtask

    task automatic wait_end(input int d0, input int e0);
        int n;
        n = 0;
        while (done_cnt + err_cnt == d0 + e0 && n < 400) begin tick(1); n++; end
        check("end_pulse_seen", 32'(done_cnt + err_cnt != d0 + e0), 1);
    endtask

    // Master model: REQ, fields 1..NF as {ID,VAL}, END; each NACK beyond the retry allowance aborts.
    task automatic run_master(input logic [CW-1:0] fields, input int nack_idx, input int nack_n);
        byte unsigned exp_b[$];
        byte unsigned b;
        int  cyc, d0, e0, nacks;
        bit  abort;
        d0 = done_cnt; e0 = err_cnt; abort = 1'b0;
        exp_b.push_back(8'hA5);
        for (int k = 1; k <= NF; k++) exp_b.push_back({4'(k), fields[(k-1)*VW +: VW]});
        exp_b.push_back(8'hF0);
        cfg_fields_i  = fields;
        cfg_req_mst_i = 1'b1;
        for (int i = 0; i < exp_b.size() && !abort; i++) begin
            nacks = (i == nack_idx) ? nack_n : 0;
            for (int a = 0; a <= nacks; a++) begin
                wait_tx(b, cyc);
                check($sformatf("mst_byte%0d_try%0d", i, a), b, exp_b[i]);
                if (i == 0 && a == 0) begin
                    cfg_req_mst_i = 1'b0;
                    cfg_fields_i  = CW'($urandom);
                end
                if (a < nacks) begin
                    rx_q.push_back(8'($urandom_range(254, 0)));
                    if (a >= RETRY_LIMIT) begin abort = 1'b1; break; end
                end else begin
                    rx_q.push_back(8'hFF);
                end
            end
        end
        wait_end(d0, e0);
        tick(2);
        if (!abort) model_cfg = fields;
        check("mst_done_pulses", done_cnt - d0, abort ? 0 : 1);
        check("mst_error_pulses", err_cnt - e0, abort ? 1 : 0);
        check("mst_cfg_o", cfg_o, model_cfg);
        check("mst_idle_after", busy_o, 0);
        check("mst_no_extra_tx", tx_q.size(), 0);
    endtask

    // Slave model: REQ is ACKed, valid fields update a copy of the config, END commits it, a bad ID aborts silently.
    task automatic run_slave();
        logic [CW-1:0] shadow;
        byte unsigned  b, p;
        logic [3:0]    id;
        int            cyc, d0, e0, outcome;
        shadow = model_cfg; d0 = done_cnt; e0 = err_cnt; outcome = 0;
        rx_q.push_back(8'hA5);
        wait_tx(b, cyc);
        check("slv_req_ack", b, 8'hFF);
        foreach (slv_pkts[i]) begin
            p  = slv_pkts[i];
            id = p[7:4];
            rx_q.push_back(p);
            if (id >= 1 && id <= NF) begin
                for (int k = 0; k < NF; k++) if (id == 4'(k + 1)) shadow[k*VW +: VW] = p[3:0];
                wait_tx(b, cyc);
                check("slv_field_ack", b, 8'hFF);
            end else if (id == 4'hF) begin
                wait_tx(b, cyc);
                check("slv_end_ack", b, 8'hFF);
                outcome = 1;
                break;
            end else begin
                outcome = 2;
                break;
            end
        end
        wait_end(d0, e0);
        tick(3);
        if (outcome == 1) model_cfg = shadow;
        check("slv_done_pulses", done_cnt - d0, (outcome == 1) ? 1 : 0);
        check("slv_error_pulses", err_cnt - e0, (outcome == 2) ? 1 : 0);
        check("slv_cfg_o", cfg_o, model_cfg);
        check("slv_idle_after", busy_o, 0);
        check("slv_no_extra_tx", tx_q.size(), 0);
    endtask

    initial begin : main
        byte unsigned b;
        int  cyc, prev_cyc, d0, e0, ni, r;
        rst_i = 1'b1; cfg_req_mst_i = 1'b0; cfg_fields_i = '0; model_cfg = '0;
        tick(3);
        rst_i = 1'b0;
        tick(2);
        check("rst_busy", busy_o, 0);
        check("rst_cfg_o", cfg_o, 0);
        check("rst_tx_write", tx_write_o, 0);
        check("rst_rx_read", rx_read_o, 0);
        check("rst_done", cfg_done_o, 0);
        check("rst_error", cfg_error_o, 0);

        run_master(12'h321, -1, 0);
        slv_pkts = '{8'h17, 8'h2A, 8'hF0};
        run_slave();
        slv_pkts = '{8'h5C};
        run_slave();
        run_master(12'hABC, 2, 1);

`ifdef UART_CFG_TIMEOUT_EN
        // Silent remote on field 2: resends spaced by send cycle + transmitter latency + timeout window.
        lat_min = 2; lat_max = 2;
        d0 = done_cnt; e0 = err_cnt;
        cfg_fields_i = 12'h321; cfg_req_mst_i = 1'b1;
        wait_tx(b, cyc); check("to_req", b, 8'hA5); cfg_req_mst_i = 1'b0; rx_q.push_back(8'hFF);
        wait_tx(b, cyc); check("to_field1", b, 8'h11); rx_q.push_back(8'hFF);
        prev_cyc = 0;
        for (int a = 0; a <= RETRIES; a++) begin
            wait_tx(b, cyc);
            check("to_field2_resend", b, 8'h22);
            if (a > 0) check("to_resend_interval", cyc - prev_cyc, TO_CYC + 2 + 1);
            prev_cyc = cyc;
        end
        wait_end(d0, e0);
        tick(2);
        check("to_error_pulse", err_cnt - e0, 1);
        check("to_no_done", done_cnt - d0, 0);
        check("to_cfg_kept", cfg_o, model_cfg);
        check("to_no_more_tx", tx_q.size(), 0);
        lat_min = 1; lat_max = 4;
`endif

        // Simultaneous slave request and master request: slave wins, master follows.
        cfg_fields_i = 12'h5C9;
        rx_q.push_back(8'hA5); cfg_req_mst_i = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        wait_tx(b, cyc); check("tie_slave_first", b, 8'hFF);
        rx_q.push_back(8'hF0);
        wait_tx(b, cyc); check("tie_end_ack", b, 8'hFF);
        wait_end(d0, e0);
        check("tie_slave_done", done_cnt - d0, 1);
        check("tie_cfg_unchanged", cfg_o, model_cfg);
        run_master(12'h5C9, -1, 0);

        // Asynchronous reset while waiting for the REQ acknowledgement.
        d0 = done_cnt; e0 = err_cnt;
        cfg_fields_i = 12'h9E4; cfg_req_mst_i = 1'b1;
        wait_tx(b, cyc); check("rst_mid_first", b, 8'hA5);
        cfg_req_mst_i = 1'b0;
        tick(8);
        check("rst_mid_busy_before", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_cfg_o", cfg_o, 0);
        model_cfg = '0;
        rx_q.delete();
        tick(2);
        rst_i = 1'b0;
        tick(2);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_no_error", err_cnt - e0, 0);
        run_master(12'h468, -1, 0);

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                ni = ($urandom_range(2, 0) == 0) ? int'($urandom_range(NF + 1, 0)) : -1;
                run_master(CW'($urandom), ni, int'($urandom_range(RETRY_LIMIT + 1, 1)));
            end else begin
                slv_pkts.delete();
                repeat ($urandom_range(4, 0)) slv_pkts.push_back({4'($urandom_range(NF, 1)), 4'($urandom)});
                if ($urandom_range(3, 0) == 0) begin
                    r = $urandom_range(11, 0);
                    slv_pkts.push_back({(r == 0) ? 4'h0 : 4'(r + 3), 4'($urandom)});
                end else begin
                    slv_pkts.push_back(8'hF0);
                end
                run_slave();
            end
        end

        check("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
